// File: rtl/tdc_fifo_sched_if.sv
// rtl/tdc_fifo_sched_if.sv - channel, FIFO and UART byte-stream signals of the TDC timestamp scheduler
interface tdc_fifo_sched_if #(
  parameter int N_CH   = 4,
  parameter int DATA_W = 48
);
  logic [N_CH-1:0]        ch_valid;
  logic [N_CH*DATA_W-1:0] ch_data;
  logic [N_CH-1:0]        ch_ack;
  logic                   fifo_wr_en;
  logic [DATA_W-1:0]      fifo_din;
  logic                   fifo_full;
  logic                   fifo_rd_en;
  logic [DATA_W-1:0]      fifo_dout;
  logic                   fifo_empty;
  logic [7:0]             tx_data;
  logic                   tx_valid;
  logic                   tx_ready;
  logic                   busy;
  logic [15:0]            word_cnt;

  modport master (
    input  ch_valid, ch_data, fifo_full, fifo_dout, fifo_empty, tx_ready,
    output ch_ack, fifo_wr_en, fifo_din, fifo_rd_en, tx_data, tx_valid, busy, word_cnt
  );

  modport slave (
    output ch_valid, ch_data, fifo_full, fifo_dout, fifo_empty, tx_ready,
    input  ch_ack, fifo_wr_en, fifo_din, fifo_rd_en, tx_data, tx_valid, busy, word_cnt
  );
endinterface

// File: rtl/tdc_fifo_sched.sv
// rtl/tdc_fifo_sched.sv - round-robin FIFO write arbiter and 6-byte MSB-first read serialiser
module tdc_fifo_sched #(
  parameter int N_CH   = 4,
  parameter int DATA_W = 48
) (
  input  logic             clk,
  input  logic             rst,
  tdc_fifo_sched_if.master bus
);
  localparam int PTR_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_POP, S_LOAD, S_SEND} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [PTR_W-1:0]  r_rr_ptr;
  logic [PTR_W-1:0]  w_grant;
  logic              w_found;
  logic              w_wr;
  logic              w_rd;
  logic              w_busy;
  logic              w_accept;
  logic [DATA_W-1:0] r_shift;
  logic [2:0]        r_byte_idx;
  logic              r_tx_valid;
  logic [15:0]       r_word_cnt;

  // Scan from the highest offset down so the nearest valid channel after rr_ptr wins.
  always_comb begin
    int k;
    k       = 0;
    w_found = 1'b0;
    w_grant = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      k = int'(r_rr_ptr) + i;
      if (k >= N_CH) k = k - N_CH;
      if (bus.ch_valid[k[PTR_W-1:0]]) begin
        w_found = 1'b1;
        w_grant = k[PTR_W-1:0];
      end
    end
  end

  assign w_wr = w_found & ~bus.fifo_full & ~rst;

  always_comb begin
    bus.ch_ack = '0;
    if (w_wr) bus.ch_ack[w_grant] = 1'b1;
  end

  assign bus.fifo_wr_en = w_wr;
  assign bus.fifo_din   = bus.ch_data[int'(w_grant)*DATA_W +: DATA_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr <= '0;
    end else if (w_wr) begin
      r_rr_ptr <= (w_grant == PTR_W'(N_CH - 1)) ? '0 : w_grant + 1'b1;
    end
  end

  assign w_accept = r_tx_valid & bus.tx_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rd        = 1'b0;
    w_busy      = 1'b1;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (!bus.fifo_empty) w_state_nxt = S_POP;
      end
      S_POP: begin
        w_rd        = 1'b1;
        w_state_nxt = S_LOAD;
      end
      S_LOAD: w_state_nxt = S_SEND;
      S_SEND: if (w_accept && r_byte_idx == 3'd5) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign bus.fifo_rd_en = w_rd;
  assign bus.busy       = w_busy;

  // tx_data is the top byte of the shift register; each accepted byte shifts the next one up.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift    <= '0;
      r_byte_idx <= 3'd0;
      r_tx_valid <= 1'b0;
      r_word_cnt <= 16'd0;
    end else if (r_state == S_LOAD) begin
      r_shift    <= bus.fifo_dout;
      r_byte_idx <= 3'd0;
      r_tx_valid <= 1'b1;
    end else if (r_state == S_SEND && w_accept) begin
      if (r_byte_idx == 3'd5) begin
        r_tx_valid <= 1'b0;
        r_word_cnt <= r_word_cnt + 16'd1;
      end else begin
        r_byte_idx <= r_byte_idx + 3'd1;
        r_shift    <= {r_shift[DATA_W-9:0], 8'h00};
      end
    end
  end

  assign bus.tx_data  = r_shift[DATA_W-1 -: 8];
  assign bus.tx_valid = r_tx_valid;
  assign bus.word_cnt = r_word_cnt;
endmodule
